// File: rtl/instr_fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch unit.
package instr_fetch_pkg;

    localparam int INSTR_BYTES    = 4;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 32;

    localparam logic [31:0] BREAK_WORD = 32'h0000_000D;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_buf.sv
// Two-entry in-order prefetch FIFO carrying {pc, instr}; flush overrides push/pop.
module fetch_buf
    import instr_fetch_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] push_pc,
    input  logic [DATA_WIDTH-1:0] push_instr,
    output logic [1:0]            count,
    output logic [ADDR_WIDTH-1:0] head_pc,
    output logic [DATA_WIDTH-1:0] head_instr
);

    logic [ADDR_WIDTH-1:0] slot_pc    [0:1];
    logic [DATA_WIDTH-1:0] slot_instr [0:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Slot 0 is always the head; payload needs no reset since count gates it.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (pop) begin
                if (count == 2'd2) begin
                    slot_pc[0]    <= slot_pc[1];
                    slot_instr[0] <= slot_instr[1];
                    if (push) begin
                        slot_pc[1]    <= push_pc;
                        slot_instr[1] <= push_instr;
                    end
                end else if (push) begin
                    slot_pc[0]    <= push_pc;
                    slot_instr[0] <= push_instr;
                end
            end else if (push) begin
                if (count == 2'd0) begin
                    slot_pc[0]    <= push_pc;
                    slot_instr[0] <= push_instr;
                end else begin
                    slot_pc[1]    <= push_pc;
                    slot_instr[1] <= push_instr;
                end
            end
        end
    end

    assign head_pc    = slot_pc[0];
    assign head_instr = slot_instr[0];

endmodule

// File: rtl/instr_fetch.sv
// Fetch initiator: PC, ROM addressing, prefetch buffer and redirect control.
// Optional BREAK halt enabled by defining INSTR_FETCH_BREAK_HALT_EN.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    BUF_DEPTH  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic [ADDR_WIDTH-1:0] o_rom_addr,
    input  logic [DATA_WIDTH-1:0] i_rom_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0] o_pc,
    input  logic                  i_redirect,
    input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
    output logic                  o_halted
);

    function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] pc);
        return pc & ~ADDR_WIDTH'(3);
    endfunction

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [1:0]            count;
    logic [ADDR_WIDTH-1:0] head_pc;
    logic [DATA_WIDTH-1:0] head_instr;
    logic                  halted;
    logic                  buf_full;
    logic                  pop;
    logic                  push;

    assign buf_full = (count == 2'(BUF_DEPTH));
    assign pop      = o_valid & i_ready;
    assign push     = !i_redirect & !halted & (!buf_full | pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_pc <= word_align(RESET_PC);
        end else if (i_redirect) begin
            fetch_pc <= word_align(i_redirect_pc);
        end else if (push) begin
            fetch_pc <= fetch_pc + ADDR_WIDTH'(INSTR_BYTES);
        end
    end

`ifdef INSTR_FETCH_BREAK_HALT_EN
    fetch_state_t state;
    logic         halted_q;

    // The BREAK word is still pushed; only later pushes are suppressed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= RUN;
            halted_q <= 1'b0;
        end else if (i_redirect) begin
            state    <= RUN;
            halted_q <= 1'b0;
        end else if (state == RUN && push && i_rom_data == DATA_WIDTH'(BREAK_WORD)) begin
            state    <= HALT;
            halted_q <= 1'b1;
        end
    end

    assign halted   = (state == HALT);
    assign o_halted = halted_q;
`else
    assign halted   = 1'b0;
    assign o_halted = 1'b0;
`endif

    fetch_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_buf (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .flush      (i_redirect),
        .push       (push),
        .pop        (pop),
        .push_pc    (fetch_pc),
        .push_instr (i_rom_data),
        .count      (count),
        .head_pc    (head_pc),
        .head_instr (head_instr)
    );

    assign o_rom_addr = {2'b00, fetch_pc[ADDR_WIDTH-1:2]};
    assign o_valid    = (count != 2'd0);
    assign o_instr    = o_valid ? head_instr : '0;
    assign o_pc       = o_valid ? head_pc : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a queue-based reference model of the fetch stream.
module tb_instr_fetch;

    localparam logic [31:0] A_W      = 32'hA000_000A;
    localparam logic [31:0] B_W      = 32'hB000_000B;
    localparam logic [31:0] C_W      = 32'hC000_000C;
    localparam logic [31:0] D_W      = 32'hD000_000D;
    localparam logic [31:0] DEF_WORD = 32'h0BAD_F00D;
    localparam logic [31:0] BRK      = 32'h0000_000D;
`ifdef INSTR_FETCH_BREAK_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        o_valid;
    logic        ready;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        redirect;
    logic [31:0] rpc;
    logic        o_halted;

    logic [31:0] mem [0:31];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign rom_data = (rom_addr < 32'd32) ? mem[rom_addr[4:0]] : DEF_WORD;

    instr_fetch dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_rom_addr    (rom_addr),
        .i_rom_data    (rom_data),
        .o_valid       (o_valid),
        .i_ready       (ready),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .i_redirect    (redirect),
        .i_redirect_pc (rpc),
        .o_halted      (o_halted)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        logic [31:0] w;
        w = pc >> 2;
        return (w < 32'd32) ? mem[w[4:0]] : DEF_WORD;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is a queue of fetched {pc, instr} in program order.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_next = 32'd0;
    bit          m_halt = 1'b0;

    initial begin
        bit pop_m;
        bit push_m;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_next = 32'd0;
                m_halt = 1'b0;
            end else if (redirect) begin
                mq.delete();
                m_next = rpc & ~32'd3;
                m_halt = 1'b0;
            end else begin
                pop_m  = (mq.size() != 0) && ready;
                push_m = !m_halt && ((mq.size() < 2) || pop_m);
                if (pop_m) void'(mq.pop_front());
                if (push_m) begin
                    mq.push_back('{pc: m_next, instr: rom_word(m_next)});
                    if (HALT_EN && rom_word(m_next) == BRK) m_halt = 1'b1;
                    m_next = m_next + 32'd4;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("cmp_valid", 64'(o_valid), 64'(mq.size() != 0));
            chk("cmp_rom_addr", 64'(rom_addr), 64'(m_next >> 2));
            chk("cmp_halted", 64'(o_halted), 64'(m_halt));
            if (mq.size() != 0) begin
                chk("cmp_pc", 64'(o_pc), 64'(mq[0].pc));
                chk("cmp_instr", 64'(o_instr), 64'(mq[0].instr));
            end else if (!rst_n) begin
                chk("cmp_rst_pc", 64'(o_pc), 64'd0);
                chk("cmp_rst_instr", 64'(o_instr), 64'd0);
            end
        end
    end

    task automatic expect_head(input string name, input logic [31:0] pc, input logic [31:0] instr);
        @(negedge clk);
        chk({name, "_valid"}, 64'(o_valid), 64'd1);
        chk({name, "_pc"}, 64'(o_pc), 64'(pc));
        chk({name, "_instr"}, 64'(o_instr), 64'(instr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        ready    = 1'b1;
        redirect = 1'b0;
        rpc      = 32'd0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = A_W;
        mem[1] = B_W;
        mem[2] = C_W;
        mem[3] = D_W;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_rom_addr", 64'(rom_addr), 64'd0);
        chk("rst_pc", 64'(o_pc), 64'd0);
        chk("rst_instr", 64'(o_instr), 64'd0);
        chk("rst_halted", 64'(o_halted), 64'd0);

        // Release and streaming
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_valid_c0", 64'(o_valid), 64'd0);
        expect_head("s1_0", 32'h0, A_W);
        expect_head("s1_4", 32'h4, B_W);
        expect_head("s1_8", 32'h8, C_W);
        expect_head("s1_c", 32'hC, D_W);

        // Stall for 5 cycles
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_pc", 64'(o_pc), 64'hC);
            chk("stall_instr", 64'(o_instr), 64'(D_W));
            chk("stall_rom_addr", 64'(rom_addr), 64'd5);
        end
        ready = 1'b1;
        expect_head("rel_10", 32'h10, 32'h1000_0004);
        expect_head("rel_14", 32'h14, 32'h1000_0005);
        expect_head("rel_18", 32'h18, 32'h1000_0006);

        // Redirect with a full buffer and a pop pending
        redirect = 1'b1;
        rpc      = 32'h0000_0042;
        @(negedge clk);
        chk("redir_valid", 64'(o_valid), 64'd0);
        chk("redir_rom_addr", 64'(rom_addr), 64'h10);
        redirect = 1'b0;
        expect_head("redir_40", 32'h40, 32'h1000_0010);

        // Asynchronous reset between edges with a full buffer
        ready = 1'b0;
        @(negedge clk);
        chk("pre_async_pc", 64'(o_pc), 64'h40);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 64'(o_valid), 64'd0);
        chk("async_rom_addr", 64'(rom_addr), 64'd0);
        ready = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel2_valid_c0", 64'(o_valid), 64'd0);
        expect_head("s4_0", 32'h0, A_W);
        expect_head("s4_4", 32'h4, B_W);

        // PC wrap
        redirect = 1'b1;
        rpc      = 32'hFFFF_FFFC;
        @(negedge clk);
        chk("wrap_valid", 64'(o_valid), 64'd0);
        chk("wrap_rom_addr_top", 64'(rom_addr), 64'h3FFF_FFFF);
        redirect = 1'b0;
        expect_head("wrap_top", 32'hFFFF_FFFC, DEF_WORD);
        chk("wrap_rom_addr_zero", 64'(rom_addr), 64'd0);
        expect_head("wrap_0", 32'h0, A_W);

        // BREAK at pc 8
        mem[2]   = BRK;
        redirect = 1'b1;
        rpc      = 32'd0;
        @(negedge clk);
        chk("brk_redir_valid", 64'(o_valid), 64'd0);
        redirect = 1'b0;
        expect_head("brk_0", 32'h0, A_W);
        expect_head("brk_4", 32'h4, B_W);
        expect_head("brk_8", 32'h8, BRK);
`ifdef INSTR_FETCH_BREAK_HALT_EN
        chk("brk_halted", 64'(o_halted), 64'd1);
        chk("brk_rom_addr", 64'(rom_addr), 64'd3);
        @(negedge clk);
        chk("halt_valid", 64'(o_valid), 64'd0);
        chk("halt_halted", 64'(o_halted), 64'd1);
        chk("halt_rom_addr", 64'(rom_addr), 64'd3);
        redirect = 1'b1;
        rpc      = 32'd0;
        @(negedge clk);
        chk("unhalt_halted", 64'(o_halted), 64'd0);
        chk("unhalt_valid", 64'(o_valid), 64'd0);
        redirect = 1'b0;
        expect_head("refetch_0", 32'h0, A_W);
`else
        chk("brk_halted", 64'(o_halted), 64'd0);
        expect_head("brk_c", 32'hC, D_W);
        chk("brk_c_halted", 64'(o_halted), 64'd0);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
